// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - shared types and sizing for the j1 I/O bus arbiter
package j1_io_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      H_DATA = 2'd1,
      H_ACK  = 2'd2
   } host_state_t;

   localparam int DEFAULT_AW = 16;
   localparam int DEFAULT_DW = 16;

   // One spare bit so MAX_WAIT-1 always fits, including MAX_WAIT = 1.
   function automatic int wait_cnt_width(input int max_wait);
      return $clog2(max_wait) + 1;
   endfunction

endpackage

// File: rtl/j1_io_starve_ctr.sv
// rtl/j1_io_starve_ctr.sv - host starvation counter and one-cycle cpu_hold register
module j1_io_starve_ctr
   import j1_io_pkg::*;
#(
   parameter int MAX_WAIT = 8
)(
   input  logic clk,
   input  logic reset,
   input  logic idle,
   input  logic host_req,
   input  logic grant,
   input  logic cpu_io_rd,
   output logic cpu_hold
);

   localparam int            CW  = wait_cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] SAT = CW'(MAX_WAIT - 1);

   logic [CW-1:0] wait_cnt;
   logic          waiting;

   assign waiting = idle & host_req & ~grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (grant || !host_req) begin
         wait_cnt <= '0;
      end else if (waiting && wait_cnt != SAT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // A held cycle always grants the host, so the hold can never repeat back to back.
   // Holding is deferred while the CPU reads so its data phase is never frozen.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_hold <= 1'b0;
      end else begin
         cpu_hold <= waiting && (wait_cnt == SAT) && !cpu_io_rd;
      end
   end

endmodule

// File: rtl/j1_io_arbiter.sv
// rtl/j1_io_arbiter.sv - shares the peripheral bus between the j1 I/O port and a host port
module j1_io_arbiter
   import j1_io_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int AW       = DEFAULT_AW,
   parameter int DW       = DEFAULT_DW
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_io_rd,
   input  logic          cpu_io_wr,
   input  logic [AW-1:0] cpu_mem_addr,
   input  logic [DW-1:0] cpu_dout,
   output logic [DW-1:0] cpu_io_din,
   output logic          cpu_hold,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          pb_rd,
   output logic          pb_wr,
   output logic [AW-1:0] pb_addr,
   output logic [DW-1:0] pb_wdata,
   input  logic [DW-1:0] pb_rdata
);

   host_state_t state;
   host_state_t state_nxt;
   logic        cpu_active;
   logic        host_grant;

   assign cpu_active = (cpu_io_rd | cpu_io_wr) & ~cpu_hold;
   assign host_grant = (state == IDLE) & host_req & (~cpu_active | cpu_hold);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (host_grant) state_nxt = H_DATA;
         H_DATA:  state_nxt = H_ACK;
         H_ACK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pb_rd    = 1'b0;
      pb_wr    = 1'b0;
      pb_addr  = '0;
      pb_wdata = '0;
      if (host_grant) begin
         pb_rd    = ~host_we;
         pb_wr    = host_we;
         pb_addr  = host_addr;
         pb_wdata = host_wdata;
      end else if (cpu_active) begin
         pb_rd    = cpu_io_rd;
         pb_wr    = cpu_io_wr;
         pb_addr  = cpu_mem_addr;
         pb_wdata = cpu_dout;
      end
      if (reset) begin
         pb_rd = 1'b0;
         pb_wr = 1'b0;
      end
      host_ack = (state == H_ACK);
   end

   // Peripheral read data lands in H_DATA; the bus is already free for the CPU then.
   always_ff @(posedge clk) begin
      if (reset) begin
         host_rdata <= '0;
      end else if (state == H_DATA && !host_we) begin
         host_rdata <= pb_rdata;
      end
   end

   assign cpu_io_din = pb_rdata;

   j1_io_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .idle      (state == IDLE),
      .host_req  (host_req),
      .grant     (host_grant),
      .cpu_io_rd (cpu_io_rd),
      .cpu_hold  (cpu_hold)
   );

endmodule

// File: tb/tb_j1_io_arbiter.sv
// tb/tb_j1_io_arbiter.sv - scoreboard bench for j1_io_arbiter with directed vectors
module tb_j1_io_arbiter;

   typedef struct {
      int          cyc;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } pb_exp_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        chk_data;
   } dat_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_io_rd, cpu_io_wr;
   logic [15:0] cpu_mem_addr, cpu_dout, cpu_io_din;
   logic        cpu_hold;
   logic        host_req, host_we;
   logic [15:0] host_addr, host_wdata, host_rdata;
   logic        host_ack;
   logic        pb_rd, pb_wr;
   logic [15:0] pb_addr, pb_wdata;
   logic [15:0] pb_rdata = 16'h0000;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int t;
   logic prev_cpu_rd = 1'b0;

   pb_exp_t  exp_pb[$];
   dat_exp_t exp_ack[$];
   dat_exp_t exp_cpu[$];
   int       exp_hold[$];

   j1_io_arbiter #(.MAX_WAIT(4), .AW(16), .DW(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_io_rd    (cpu_io_rd),
      .cpu_io_wr    (cpu_io_wr),
      .cpu_mem_addr (cpu_mem_addr),
      .cpu_dout     (cpu_dout),
      .cpu_io_din   (cpu_io_din),
      .cpu_hold     (cpu_hold),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_ack     (host_ack),
      .host_rdata   (host_rdata),
      .pb_rd        (pb_rd),
      .pb_wr        (pb_wr),
      .pb_addr      (pb_addr),
      .pb_wdata     (pb_wdata),
      .pb_rdata     (pb_rdata)
   );

   always #5 clk = ~clk;

   // Peripheral: read data for address A is A ^ 0x3236, one cycle after pb_rd.
   always @(posedge clk) begin
      pb_rdata <= pb_rd ? (pb_addr ^ 16'h3236) : 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cpu_set(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      cpu_io_rd = rd; cpu_io_wr = wr; cpu_mem_addr = a; cpu_dout = d;
   endtask

   task automatic host_set(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
      host_req = req; host_we = we; host_addr = a; host_wdata = d;
   endtask

   task automatic push_pb(input int c, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      exp_pb.push_back('{c, rd, wr, a, d});
   endtask

   task automatic push_ack(input int c, input logic [15:0] d, input logic chk_data);
      exp_ack.push_back('{c, d, chk_data});
   endtask

   task automatic push_cpu(input int c, input logic [15:0] d);
      exp_cpu.push_back('{c, d, 1'b1});
   endtask

   always @(negedge clk) begin : monitor
      pb_exp_t  pe;
      dat_exp_t de;
      int       hc;
      if ((pb_rd | pb_wr) === 1'b1) begin
         if (exp_pb.size() == 0) unexpected("pb_xfer");
         else begin
            pe = exp_pb.pop_front();
            chk("pb_cycle", cyc, pe.cyc);
            chk("pb_rd", pb_rd, pe.rd);
            chk("pb_wr", pb_wr, pe.wr);
            chk("pb_addr", pb_addr, pe.addr);
            chk("pb_wdata", pb_wdata, pe.wdata);
         end
      end
      if (host_ack === 1'b1) begin
         if (exp_ack.size() == 0) unexpected("host_ack");
         else begin
            de = exp_ack.pop_front();
            chk("ack_cycle", cyc, de.cyc);
            if (de.chk_data) chk("host_rdata", host_rdata, de.data);
         end
      end
      if (cpu_hold === 1'b1) begin
         if (exp_hold.size() == 0) unexpected("cpu_hold");
         else begin
            hc = exp_hold.pop_front();
            chk("hold_cycle", cyc, hc);
         end
      end
      if (prev_cpu_rd) begin
         if (exp_cpu.size() == 0) unexpected("cpu_read_data");
         else begin
            de = exp_cpu.pop_front();
            chk("cpu_din_cycle", cyc, de.cyc);
            chk("cpu_io_din", cpu_io_din, de.data);
         end
      end
      prev_cpu_rd = (cpu_io_rd & ~cpu_hold & ~reset) === 1'b1;
   end

   initial begin
      reset = 1'b1;
      cpu_set(1'b0, 1'b1, 16'h0042, 16'h0042);
      host_set(1'b1, 1'b0, 16'h0099, 16'h0000);
      step();
      chk("rst_pb_wr_forced", pb_wr, 1'b0);
      chk("rst_pb_rd_forced", pb_rd, 1'b0);
      cpu_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      chk("rst_cpu_hold", cpu_hold, 1'b0);
      chk("rst_host_ack", host_ack, 1'b0);
      chk("rst_host_rdata", host_rdata, 16'h0000);
      reset = 1'b0;
      step();

      // Host write with idle CPU
      step(); t = cyc;
      host_set(1'b1, 1'b1, 16'h1000, 16'hBEEF);
      push_pb(t, 1'b0, 1'b1, 16'h1000, 16'hBEEF);
      push_ack(t + 2, 16'h0000, 1'b0);
      step(); step(); step();
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();

      // Host read, peripheral returns 0x1234
      step(); t = cyc;
      host_set(1'b1, 1'b0, 16'h2002, 16'h0000);
      push_pb(t, 1'b1, 1'b0, 16'h2002, 16'h0000);
      push_ack(t + 2, 16'h1234, 1'b1);
      step(); step(); step();
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();

      // CPU writes every cycle; starvation forces a hold in cycle 4
      step(); t = cyc;
      host_set(1'b1, 1'b1, 16'h3000, 16'h5555);
      for (int i = 0; i < 4; i++) push_pb(t + i, 1'b0, 1'b1, 16'(16'h0100 + i), 16'(16'hC000 + i));
      push_pb(t + 4, 1'b0, 1'b1, 16'h3000, 16'h5555);
      push_pb(t + 5, 1'b0, 1'b1, 16'h0104, 16'hC004);
      push_pb(t + 6, 1'b0, 1'b1, 16'h0105, 16'hC005);
      exp_hold.push_back(t + 4);
      push_ack(t + 6, 16'h0000, 1'b0);
      for (int i = 0; i < 7; i++) begin
         int k;
         k = (i < 5) ? i : i - 1;
         cpu_set(1'b0, 1'b1, 16'(16'h0100 + k), 16'(16'hC000 + k));
         step();
      end
      cpu_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step(); step();

      // CPU read run defers the hold until the first non-read cycle
      step(); t = cyc;
      host_set(1'b1, 1'b0, 16'h4000, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         push_pb(t + i, 1'b1, 1'b0, 16'(16'h0200 + i), 16'h0000);
         push_cpu(t + i + 1, 16'(16'h0200 + i) ^ 16'h3236);
      end
      push_pb(t + 6, 1'b0, 1'b1, 16'h0300, 16'hAAAA);
      push_pb(t + 7, 1'b1, 1'b0, 16'h4000, 16'h0000);
      push_pb(t + 8, 1'b0, 1'b1, 16'h0300, 16'hAAAA);
      exp_hold.push_back(t + 7);
      push_ack(t + 9, 16'h7236, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (i < 6)      cpu_set(1'b1, 1'b0, 16'(16'h0200 + i), 16'h0000);
         else if (i < 9) cpu_set(1'b0, 1'b1, 16'h0300, 16'hAAAA);
         else            cpu_set(1'b0, 1'b0, 16'h0000, 16'h0000);
         step();
      end
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step(); step();

      // Simultaneous CPU read and host read: CPU first, host next cycle
      step(); t = cyc;
      host_set(1'b1, 1'b0, 16'h5000, 16'h0000);
      push_pb(t, 1'b1, 1'b0, 16'h0500, 16'h0000);
      push_pb(t + 1, 1'b1, 1'b0, 16'h5000, 16'h0000);
      push_pb(t + 2, 1'b1, 1'b0, 16'h0502, 16'h0000);
      push_cpu(t + 1, 16'h3736);
      push_cpu(t + 3, 16'h3734);
      push_ack(t + 3, 16'h6236, 1'b1);
      cpu_set(1'b1, 1'b0, 16'h0500, 16'h0000); step();
      cpu_set(1'b0, 1'b0, 16'h0000, 16'h0000); step();
      cpu_set(1'b1, 1'b0, 16'h0502, 16'h0000); step();
      cpu_set(1'b0, 1'b0, 16'h0000, 16'h0000); step();
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step(); step();

      // Reset during H_DATA aborts the read; a re-issued read completes
      step(); t = cyc;
      host_set(1'b1, 1'b0, 16'h2002, 16'h0000);
      push_pb(t, 1'b1, 1'b0, 16'h2002, 16'h0000);
      step();
      reset = 1'b1;
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step();
      reset = 1'b0;
      chk("abort_host_ack", host_ack, 1'b0);
      chk("abort_host_rdata", host_rdata, 16'h0000);
      chk("abort_cpu_hold", cpu_hold, 1'b0);
      chk("abort_pb_rd", pb_rd, 1'b0);
      step(); step(); step();
      t = cyc;
      host_set(1'b1, 1'b0, 16'h2002, 16'h0000);
      push_pb(t, 1'b1, 1'b0, 16'h2002, 16'h0000);
      push_ack(t + 2, 16'h1234, 1'b1);
      step(); step(); step();
      host_set(1'b0, 1'b0, 16'h0000, 16'h0000);
      step(); step(); step();

      chk("pb_queue_drained", exp_pb.size(), 0);
      chk("ack_queue_drained", exp_ack.size(), 0);
      chk("cpu_queue_drained", exp_cpu.size(), 0);
      chk("hold_queue_drained", exp_hold.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
